// File: rtl/mini_alu_pkg.sv
// Shared opcodes and FSM state encoding for the two-requester mini-ALU arbiter.
package mini_alu_pkg;

  localparam logic [1:0] OP_LT  = 2'b00;
  localparam logic [1:0] OP_GE  = 2'b01;
  localparam logic [1:0] OP_EQ  = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mini_alu_arbiter_if.sv
// Request/response bundle between the two operand sources, the consumer and the arbiter.
interface mini_alu_arbiter_if #(
  parameter int WIDTH = 6
);

  logic                    req0_valid;
  logic                    req0_ready;
  logic [1:0]              req0_op;
  logic signed [WIDTH-1:0] req0_a;
  logic signed [WIDTH-1:0] req0_b;

  logic                    req1_valid;
  logic                    req1_ready;
  logic [1:0]              req1_op;
  logic signed [WIDTH-1:0] req1_a;
  logic signed [WIDTH-1:0] req1_b;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_id;
  logic [WIDTH-1:0]        rsp_result;
  logic                    rsp_ovf;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_ovf
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_ovf
  );

endinterface

// File: rtl/mini_alu_core.sv
// Combinational shared datapath: signed compares (2-bit guard extension) and wrapping add.
module mini_alu_core
  import mini_alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [1:0]              op,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic [WIDTH-1:0]        result,
  output logic                    ovf
);

  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic signed [WIDTH+1:0] a_ext;
  logic signed [WIDTH+1:0] b_ext;
  logic                    lt;
  logic                    eq;
  logic [WIDTH-1:0]        sum;

  assign a_ext = {{2{a[WIDTH-1]}}, a};
  assign b_ext = {{2{b[WIDTH-1]}}, b};
  assign lt    = (a_ext < b_ext);
  assign eq    = (a == b);
  assign sum   = a + b;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_LT:   result = {{(WIDTH-1){1'b0}}, lt};
      OP_GE:   result = {{(WIDTH-1){1'b0}}, ~lt};
      OP_EQ:   result = {{(WIDTH-1){1'b0}}, eq};
      OP_ADD: begin
        result = sum;
        ovf    = add_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mini_alu_arbiter.sv
// Round-robin share of one mini-ALU core between two requesters: grant, capture, execute, hold response.
module mini_alu_arbiter
  import mini_alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input logic               clk,
  input logic               reset,
  mini_alu_arbiter_if.slave bus
);

  state_t state;
  state_t state_nxt;
  logic   rr_last;
  logic   grant0;
  logic   grant1;

  logic [1:0]              cap_op_p0;
  logic signed [WIDTH-1:0] cap_a_p0;
  logic signed [WIDTH-1:0] cap_b_p0;
  logic                    cap_id_p0;

  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;

  logic             vld_p1;
  logic             rsp_id_p1;
  logic [WIDTH-1:0] rsp_result_p1;
  logic             rsp_ovf_p1;

  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      S_IDLE: begin
        // rr_last==1 means requester 1 was served last, so requester 0 wins a tie
        if (bus.req0_valid && (!bus.req1_valid || rr_last)) begin
          grant0 = 1'b1;
        end else if (bus.req1_valid) begin
          grant1 = 1'b1;
        end
        if (grant0 || grant1) begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: state_nxt = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.req0_ready = grant0 & ~reset;
  assign bus.req1_ready = grant1 & ~reset;

  // Stage p0: operand capture at grant
  always_ff @(posedge clk) begin
    if (grant0) begin
      cap_op_p0 <= bus.req0_op;
      cap_a_p0  <= bus.req0_a;
      cap_b_p0  <= bus.req0_b;
      cap_id_p0 <= 1'b0;
    end else if (grant1) begin
      cap_op_p0 <= bus.req1_op;
      cap_a_p0  <= bus.req1_a;
      cap_b_p0  <= bus.req1_b;
      cap_id_p0 <= 1'b1;
    end
  end

  mini_alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op    (cap_op_p0),
    .a     (cap_a_p0),
    .b     (cap_b_p0),
    .result(alu_result),
    .ovf   (alu_ovf)
  );

  // Stage p1: registered response, held until the consumer accepts it
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      rr_last       <= 1'b1;
      vld_p1        <= 1'b0;
      rsp_id_p1     <= 1'b0;
      rsp_result_p1 <= '0;
      rsp_ovf_p1    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant0 || grant1) begin
        rr_last <= grant1;
      end
      if (state == S_EXEC) begin
        vld_p1        <= 1'b1;
        rsp_id_p1     <= cap_id_p0;
        rsp_result_p1 <= alu_result;
        rsp_ovf_p1    <= alu_ovf;
      end else if ((state == S_RESP) && bus.rsp_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid  = vld_p1;
  assign bus.rsp_id     = rsp_id_p1;
  assign bus.rsp_result = rsp_result_p1;
  assign bus.rsp_ovf    = rsp_ovf_p1;

endmodule

// File: tb/tb_mini_alu_arbiter.sv
// Directed bench for mini_alu_arbiter: arbitration order, compare/add results, backpressure, reset.
module tb_mini_alu_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mini_alu_arbiter_if #(.WIDTH(6)) bus ();

  mini_alu_arbiter #(.WIDTH(6)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic id, input logic [5:0] res, input logic ovf);
    chk({tag, "_vld"}, {7'b0, bus.rsp_valid}, 8'h01);
    chk({tag, "_id"},  {7'b0, bus.rsp_id}, {7'b0, id});
    chk({tag, "_res"}, {2'b0, bus.rsp_result}, {2'b0, res});
    chk({tag, "_ovf"}, {7'b0, bus.rsp_ovf}, {7'b0, ovf});
  endtask

  // Expects to be entered in IDLE with requests already driven.
  task automatic txn(input string tag, input logic [1:0] g, input logic id,
                     input logic [5:0] res, input logic ovf);
    #1;
    chk({tag, "_grant"}, {6'b0, bus.req1_ready, bus.req0_ready}, {6'b0, g});
    bus.rsp_ready = 1'b1;
    tick();
    chk({tag, "_exec_vld"}, {7'b0, bus.rsp_valid}, 8'h00);
    chk({tag, "_exec_rdy"}, {6'b0, bus.req1_ready, bus.req0_ready}, 8'h00);
    tick();
    chk_rsp(tag, id, res, ovf);
    tick();
    chk({tag, "_done_vld"}, {7'b0, bus.rsp_valid}, 8'h00);
  endtask

  task automatic set_req(input logic idx, input logic v, input logic [1:0] op,
                         input logic [5:0] a, input logic [5:0] b);
    if (idx == 1'b0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    set_req(1'b0, 1'b0, 2'b00, 6'h00, 6'h00);
    set_req(1'b1, 1'b0, 2'b00, 6'h00, 6'h00);
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_vld", {7'b0, bus.rsp_valid}, 8'h00);
    chk("rst_id",  {7'b0, bus.rsp_id}, 8'h00);
    chk("rst_res", {2'b0, bus.rsp_result}, 8'h00);
    chk("rst_ovf", {7'b0, bus.rsp_ovf}, 8'h00);
    chk("rst_rdy", {6'b0, bus.req1_ready, bus.req0_ready}, 8'h00);

    // Single requester, -1 < 1
    set_req(1'b0, 1'b1, 2'b00, 6'h3F, 6'h01);
    bus.rsp_ready = 1'b1;
    #1;
    chk("t1_grant", {6'b0, bus.req1_ready, bus.req0_ready}, 8'h01);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("t1_rdy_drop", {6'b0, bus.req1_ready, bus.req0_ready}, 8'h00);
    chk("t1_exec_vld", {7'b0, bus.rsp_valid}, 8'h00);
    tick();
    chk_rsp("t1", 1'b0, 6'h01, 1'b0);
    tick();
    chk("t1_done_vld", {7'b0, bus.rsp_valid}, 8'h00);

    // Both held: round robin 0,1,0
    do_reset();
    set_req(1'b0, 1'b1, 2'b11, 6'h01, 6'h02);
    set_req(1'b1, 1'b1, 2'b01, 6'h20, 6'h1F);
    txn("t2a", 2'b01, 1'b0, 6'h03, 1'b0);
    txn("t2b", 2'b10, 1'b1, 6'h00, 1'b0);
    txn("t2c", 2'b01, 1'b0, 6'h03, 1'b0);

    // Add overflow / no overflow
    bus.req1_valid = 1'b0;
    set_req(1'b0, 1'b1, 2'b11, 6'h1F, 6'h01);
    txn("t3a", 2'b01, 1'b0, 6'h20, 1'b1);
    set_req(1'b0, 1'b1, 2'b11, 6'h3F, 6'h3F);
    txn("t3b", 2'b01, 1'b0, 6'h3E, 1'b0);
    bus.req0_valid = 1'b0;

    // Equality from requester 1
    set_req(1'b1, 1'b1, 2'b10, 6'h2A, 6'h2A);
    txn("t6a", 2'b10, 1'b1, 6'h01, 1'b0);
    set_req(1'b1, 1'b1, 2'b10, 6'h2A, 6'h2B);
    txn("t6b", 2'b10, 1'b1, 6'h00, 1'b0);
    bus.req1_valid = 1'b0;

    // Backpressure: response held 5 cycles, no grants meanwhile
    set_req(1'b0, 1'b1, 2'b11, 6'h05, 6'h03);
    bus.rsp_ready = 1'b0;
    #1;
    chk("t4_grant", {6'b0, bus.req1_ready, bus.req0_ready}, 8'h01);
    tick();
    set_req(1'b1, 1'b1, 2'b00, 6'h01, 6'h02);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_rsp("t4_hold", 1'b0, 6'h08, 1'b0);
      chk("t4_hold_rdy", {6'b0, bus.req1_ready, bus.req0_ready}, 8'h00);
      tick();
    end
    chk_rsp("t4_still", 1'b0, 6'h08, 1'b0);
    bus.rsp_ready = 1'b1;
    tick();
    txn("t4_next", 2'b10, 1'b1, 6'h01, 1'b0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Reset while executing: op dropped, arbitration pointer restored
    set_req(1'b0, 1'b1, 2'b11, 6'h01, 6'h01);
    #1;
    chk("t5_grant", {6'b0, bus.req1_ready, bus.req0_ready}, 8'h01);
    tick();
    bus.req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_vld", {7'b0, bus.rsp_valid}, 8'h00);
    chk("t5_res", {2'b0, bus.rsp_result}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_stale", {7'b0, bus.rsp_valid}, 8'h00);
      chk("t5_no_rdy", {6'b0, bus.req1_ready, bus.req0_ready}, 8'h00);
    end
    set_req(1'b0, 1'b1, 2'b10, 6'h05, 6'h05);
    set_req(1'b1, 1'b1, 2'b11, 6'h01, 6'h01);
    txn("t5_rr", 2'b01, 1'b0, 6'h01, 1'b0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
